// File: rtl/stopwatch_pkg.sv
// Shared constants for the MM:SS.cc BCD stopwatch: digit maxima and control state encoding.
package stopwatch_pkg;

    localparam logic [3:0] DIG_MAX_9 = 4'd9;
    localparam logic [3:0] DIG_MAX_5 = 4'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch chain: counts 0..MAX on inc, clr has priority.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    assign carry = inc & (q_q == MAX);
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = 4'd0;
        else if (inc)
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end

    always_ff @(posedge clkin) begin
        if (rst)
            q_q <= 4'd0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc BCD stopwatch driven by rising edges of the 1 kHz divided clock,
// with synchronized start/stop and clear buttons.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] cs_lo,
    output logic [3:0] cs_hi,
    output logic [3:0] s_lo,
    output logic [3:0] s_hi,
    output logic [3:0] m_lo,
    output logic [3:0] m_hi,
    output logic       running,
    output logic       wrap
);

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_CS - 1);

    logic                   tick_q, tick_d;
    logic                   armed_q, armed_d;
    logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
    logic [SYNC_STAGES-1:0] clear_sync_q, clear_sync_d;
    logic                   start_prev_q, start_prev_d;
    logic                   clear_prev_q, clear_prev_d;
    state_e                 state_q, state_d;
    logic [7:0]             pre_q, pre_d;
    logic                   wrap_q, wrap_d;

    logic tick_pulse, start_p, clear_p, cs_inc;
    logic c_cs_lo, c_cs_hi, c_s_lo, c_s_hi, c_m_lo, c_m_hi;

    // armed_q masks the first post-reset cycle so a tick_in already high at release is not an edge
    assign tick_pulse = tick_in & ~tick_q & armed_q;
    assign start_p    = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
    assign clear_p    = clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;

    always_comb begin
        tick_d       = tick_in;
        armed_d      = 1'b1;
        start_sync_d = {start_sync_q[SYNC_STAGES-2:0], btn_start};
        clear_sync_d = {clear_sync_q[SYNC_STAGES-2:0], btn_clear};
        start_prev_d = start_sync_q[SYNC_STAGES-1];
        clear_prev_d = clear_sync_q[SYNC_STAGES-1];

        state_d = state_q;
        if (start_p)
            state_d = (state_q == ST_RUN) ? ST_IDLE : ST_RUN;

        // Prescaler follows the current state, so a tick coinciding with a stop is still counted
        pre_d  = pre_q;
        cs_inc = 1'b0;
        if (clear_p) begin
            pre_d = 8'd0;
        end else if (state_q == ST_RUN && tick_pulse) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = 8'd0;
                cs_inc = 1'b1;
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end

        wrap_d = c_m_hi & ~clear_p;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            tick_q       <= 1'b0;
            armed_q      <= 1'b0;
            start_sync_q <= '0;
            clear_sync_q <= '0;
            start_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            pre_q        <= 8'd0;
            wrap_q       <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            armed_q      <= armed_d;
            start_sync_q <= start_sync_d;
            clear_sync_q <= clear_sync_d;
            start_prev_q <= start_prev_d;
            clear_prev_q <= clear_prev_d;
            state_q      <= state_d;
            pre_q        <= pre_d;
            wrap_q       <= wrap_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign wrap    = wrap_q;

    bcd_digit #(.MAX(DIG_MAX_9)) u_cs_lo (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(cs_inc),  .q(cs_lo), .carry(c_cs_lo));
    bcd_digit #(.MAX(DIG_MAX_9)) u_cs_hi (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(c_cs_lo), .q(cs_hi), .carry(c_cs_hi));
    bcd_digit #(.MAX(DIG_MAX_9)) u_s_lo  (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(c_cs_hi), .q(s_lo),  .carry(c_s_lo));
    bcd_digit #(.MAX(DIG_MAX_5)) u_s_hi  (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(c_s_lo),  .q(s_hi),  .carry(c_s_hi));
    bcd_digit #(.MAX(DIG_MAX_9)) u_m_lo  (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(c_s_hi),  .q(m_lo),  .carry(c_m_lo));
    bcd_digit #(.MAX(DIG_MAX_5)) u_m_hi  (.clkin(clkin), .rst(rst), .clr(clear_p), .inc(c_m_lo),  .q(m_hi),  .carry(c_m_hi));

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICKS_PER_CS=2, SYNC_STAGES=2.
module tb_stopwatch_bcd;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
    logic       running, wrap;
    logic [23:0] dig;
    int n_chk = 0;
    int n_fail = 0;
    int wrap_cnt = 0;

    assign dig = {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo};

    stopwatch_bcd #(.TICKS_PER_CS(2), .SYNC_STAGES(2)) dut (
        .clkin(clkin), .rst(rst), .tick_in(tick_in),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .cs_lo(cs_lo), .cs_hi(cs_hi), .s_lo(s_lo), .s_hi(s_hi),
        .m_lo(m_lo), .m_hi(m_hi), .running(running), .wrap(wrap)
    );

    always #10 clkin = ~clkin;

    always @(negedge clkin) if (wrap === 1'b1) wrap_cnt++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clkin) tick_in = 1'b1;
            @(negedge clkin) tick_in = 1'b0;
        end
    endtask

    task automatic press(input bit s, input bit c);
        @(negedge clkin);
        btn_start = s; btn_clear = c;
        repeat (4) @(negedge clkin);
        btn_start = 1'b0; btn_clear = 1'b0;
        repeat (4) @(negedge clkin);
    endtask

    // Button pulses land on the 3rd edge after the press; the tick is raised so its pulse hits that edge too
    task automatic press_with_tick(input bit s, input bit c);
        @(negedge clkin);
        btn_start = s; btn_clear = c;
        @(negedge clkin);
        @(negedge clkin) tick_in = 1'b1;
        @(negedge clkin) tick_in = 1'b0;
        btn_start = 1'b0; btn_clear = 1'b0;
        repeat (4) @(negedge clkin);
    endtask

    // Held across one idle edge so the flops latch the forced value before release
    task automatic preload(input bit full);
        @(negedge clkin);
        force dut.u_cs_lo.q_q = 4'd9;
        force dut.u_cs_hi.q_q = 4'd9;
        force dut.u_s_lo.q_q  = 4'd9;
        force dut.u_s_hi.q_q  = 4'd5;
        if (full) begin
            force dut.u_m_lo.q_q = 4'd9;
            force dut.u_m_hi.q_q = 4'd5;
        end else begin
            force dut.u_m_lo.q_q = 4'd0;
            force dut.u_m_hi.q_q = 4'd0;
        end
        @(negedge clkin);
        release dut.u_cs_lo.q_q;
        release dut.u_cs_hi.q_q;
        release dut.u_s_lo.q_q;
        release dut.u_s_hi.q_q;
        release dut.u_m_lo.q_q;
        release dut.u_m_hi.q_q;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkin) tick_in = ((i % 4) < 2);
        end
        n_chk++; if (dig !== 24'h0 || running !== 1'b0) begin n_fail++; $display("FAIL reset_hold: dig %h run %b, want 000000 run 0", dig, running); end
        rst = 1'b0;
        for (int i = 20; i < 36; i++) begin
            @(negedge clkin) tick_in = ((i % 4) < 2);
        end
        tick_in = 1'b0;
        @(negedge clkin);
        n_chk++; if (dig !== 24'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 000000", dig); end
        n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
        n_chk++; if (wrap_cnt !== 0) begin n_fail++; $display("FAIL reset_wrap: %0d wrap pulses, want 0", wrap_cnt); end
    endtask

    task automatic test_count;
        press(1'b1, 1'b0);
        n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL count_start: running %b want 1", running); end
        tick(20);
        n_chk++; if (dig !== 24'h000010) begin n_fail++; $display("FAIL count_20ticks: got %h want 000010", dig); end
        n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL count_running: got %b want 1", running); end
    endtask

    task automatic test_pause_resume;
        press(1'b0, 1'b1);
        n_chk++; if (dig !== 24'h0 || running !== 1'b1) begin n_fail++; $display("FAIL pause_clear: dig %h run %b, want 000000 run 1", dig, running); end
        tick(6);
        n_chk++; if (dig !== 24'h000003) begin n_fail++; $display("FAIL pause_6ticks: got %h want 000003", dig); end
        press(1'b1, 1'b0);
        n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_stop: running %b want 0", running); end
        tick(10);
        n_chk++; if (dig !== 24'h000003) begin n_fail++; $display("FAIL pause_hold: got %h want 000003", dig); end
        press(1'b1, 1'b0);
        tick(2);
        n_chk++; if (dig !== 24'h000004 || running !== 1'b1) begin n_fail++; $display("FAIL pause_resume: dig %h run %b, want 000004 run 1", dig, running); end
    endtask

    task automatic test_carry_chain;
        press(1'b0, 1'b1);
        preload(1'b0);
        n_chk++; if (dig !== 24'h005999) begin n_fail++; $display("FAIL carry_preload: got %h want 005999", dig); end
        tick(1);
        n_chk++; if (dig !== 24'h005999) begin n_fail++; $display("FAIL carry_half: got %h want 005999", dig); end
        @(negedge clkin) tick_in = 1'b1;
        @(negedge clkin) tick_in = 1'b0;
        n_chk++; if (dig !== 24'h010000) begin n_fail++; $display("FAIL carry_ripple: got %h want 010000", dig); end
        @(negedge clkin);
    endtask

    task automatic test_wrap;
        int w0;
        press(1'b0, 1'b1);
        preload(1'b1);
        n_chk++; if (dig !== 24'h595999) begin n_fail++; $display("FAIL wrap_preload: got %h want 595999", dig); end
        tick(1);
        w0 = wrap_cnt;
        @(negedge clkin) tick_in = 1'b1;
        @(negedge clkin) tick_in = 1'b0;
        n_chk++; if (dig !== 24'h0 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_roll: dig %h wrap %b, want 000000 wrap 1", dig, wrap); end
        @(negedge clkin);
        n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_width: wrap %b want 0", wrap); end
        repeat (4) @(negedge clkin);
        n_chk++; if (wrap_cnt - w0 !== 1) begin n_fail++; $display("FAIL wrap_count: %0d pulses want 1", wrap_cnt - w0); end
        n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL wrap_running: got %b want 1", running); end
        tick(2);
        n_chk++; if (dig !== 24'h000001) begin n_fail++; $display("FAIL wrap_continue: got %h want 000001", dig); end
    endtask

    task automatic test_clear_priority;
        int w0;
        press(1'b0, 1'b1);
        tick(19);
        n_chk++; if (dig !== 24'h000009) begin n_fail++; $display("FAIL clr_setup: got %h want 000009", dig); end
        w0 = wrap_cnt;
        press_with_tick(1'b0, 1'b1);
        n_chk++; if (dig !== 24'h0 || running !== 1'b1) begin n_fail++; $display("FAIL clr_vs_inc: dig %h run %b, want 000000 run 1", dig, running); end
        n_chk++; if (wrap_cnt !== w0) begin n_fail++; $display("FAIL clr_wrap: %0d pulses want 0", wrap_cnt - w0); end
        tick(2);
        n_chk++; if (dig !== 24'h000001) begin n_fail++; $display("FAIL clr_prescaler: got %h want 000001", dig); end
        press(1'b1, 1'b1);
        n_chk++; if (dig !== 24'h0 || running !== 1'b0) begin n_fail++; $display("FAIL clr_and_start: dig %h run %b, want 000000 run 0", dig, running); end
    endtask

    task automatic test_stop_with_tick;
        press(1'b1, 1'b0);
        tick(1);
        press_with_tick(1'b1, 1'b0);
        n_chk++; if (dig !== 24'h000001 || running !== 1'b0) begin n_fail++; $display("FAIL stop_tick: dig %h run %b, want 000001 run 0", dig, running); end
        tick(4);
        n_chk++; if (dig !== 24'h000001) begin n_fail++; $display("FAIL stop_hold: got %h want 000001", dig); end
    endtask

    task automatic test_reset_mid_count;
        press(1'b1, 1'b0);
        tick(3);
        @(negedge clkin) rst = 1'b1;
        @(negedge clkin) rst = 1'b0;
        n_chk++; if (dig !== 24'h0 || running !== 1'b0) begin n_fail++; $display("FAIL reset_mid: dig %h run %b, want 000000 run 0", dig, running); end
        tick(4);
        n_chk++; if (dig !== 24'h0) begin n_fail++; $display("FAIL reset_idle: got %h want 000000", dig); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause_resume();
        test_carry_chain();
        test_wrap();
        test_clear_priority();
        test_stop_with_tick();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
